// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size codes, dump FSM states, alignment helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package data_mem_unit_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_ADDR_DEF = 5;
   localparam int NB_TYPE_DEF = 3;

   // Access-size codes as issued by the memory controller.
   localparam logic [NB_TYPE_DEF-1:0] BYTE_WORD     = 3'b000;
   localparam logic [NB_TYPE_DEF-1:0] HALF_WORD     = 3'b001;
   localparam logic [NB_TYPE_DEF-1:0] COMPLETE_WORD = 3'b010;

   // Debug dump engine states.
   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_SEND = 2'd1,
      DMEM_DONE = 2'd2
   } dmem_state_e;

   // Size/offset alignment rule, independent of whether an access is requested.
   // Undefined size codes are always treated as misaligned so they can never write.
   function automatic logic size_misaligned(input logic [NB_TYPE_DEF-1:0] size,
                                            input logic [1:0]             offset);
      logic bad;
      case (size)
         BYTE_WORD:     bad = 1'b0;
         HALF_WORD:     bad = offset[0];
         COMPLETE_WORD: bad = (offset != 2'b00);
         default:       bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Load/store and debug-dump bus between the memory controller / debug unit and the data memory.
// Latency: n/a (wires only).
// Backpressure: dump words are held by the memory side until i_dump_ready is seen with o_dump_valid.
interface data_mem_unit_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_TYPE = 3
) ();

   logic               i_write;
   logic               i_read;
   logic [NB_TYPE-1:0] i_word_size;
   logic [NB_DATA-1:0] i_addr;
   logic [NB_DATA-1:0] i_write_data;
   logic [NB_DATA-1:0] o_read_data;
   logic               o_misaligned;

   logic               i_dump_start;
   logic               i_dump_ready;
   logic               o_dump_valid;
   logic [NB_DATA-1:0] o_dump_data;
   logic [NB_ADDR-1:0] o_dump_addr;
   logic               o_dump_busy;
   logic               o_dump_done;

   // Controller / debug-unit side.
   modport master (
      output i_write, i_read, i_word_size, i_addr, i_write_data,
      output i_dump_start, i_dump_ready,
      input  o_read_data, o_misaligned,
      input  o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done
   );

   // Memory side.
   modport slave (
      input  i_write, i_read, i_word_size, i_addr, i_write_data,
      input  i_dump_start, i_dump_ready,
      output o_read_data, o_misaligned,
      output o_dump_valid, o_dump_data, o_dump_addr, o_dump_busy, o_dump_done
   );

endinterface

// File: rtl/data_mem_unit_dump_fsm.sv
// Dump engine: walks a word pointer over the whole memory, one word per valid/ready handshake.
// Latency: first word valid the cycle after start is sampled; done pulses one cycle after the last accept.
// Backpressure: holds SEND with a stable pointer while i_dump_ready is low.
module dmem_dump_fsm
   import data_mem_unit_pkg::*;
#(
   parameter int NB_ADDR = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_dump_start,
   input  logic               i_dump_ready,
   output logic               o_dump_valid,
   output logic               o_dump_busy,
   output logic               o_dump_done,
   output logic [NB_ADDR-1:0] o_dump_addr
);

   localparam logic [NB_ADDR-1:0] LAST_PTR = '1;

   dmem_state_e        state_q, state_d;
   logic [NB_ADDR-1:0] ptr_q, ptr_d;

   // State and pointer registers; reset parks the engine in IDLE at word 0.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= DMEM_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state, pointer advance on accepted words, and status outputs.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      o_dump_valid = 1'b0;
      o_dump_busy  = 1'b0;
      o_dump_done  = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            if (i_dump_start) begin
               state_d = DMEM_SEND;
               ptr_d   = '0;
            end
         end
         DMEM_SEND: begin
            o_dump_valid = 1'b1;
            o_dump_busy  = 1'b1;
            if (i_dump_ready) begin
               if (ptr_q == LAST_PTR) begin
                  state_d = DMEM_DONE;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         DMEM_DONE: begin
            o_dump_busy = 1'b1;
            o_dump_done = 1'b1;
            state_d     = DMEM_IDLE;
         end
         default: begin
            state_d = DMEM_IDLE;
         end
      endcase
   end

   assign o_dump_addr = ptr_q;

endmodule

// File: rtl/data_mem_unit.sv
// Word-organised data memory with byte-lane stores, lane-shifted loads, alignment check; dump engine under DMEM_DEBUG_DUMP_EN.
// Latency: loads combinational (0 cycles); stores visible the cycle after the edge.
// Backpressure: stores are dropped while the dump engine is busy; dump words wait for i_dump_ready.
module data_mem_unit
   import data_mem_unit_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_TYPE = 3
) (
   input  logic            i_clock,
   input  logic            i_reset,
   data_mem_unit_if.slave  bus
);

   localparam int DEPTH    = 1 << NB_ADDR;
   localparam int NB_LANES = NB_DATA / 8;

   logic [NB_DATA-1:0]  mem_q [DEPTH];
   logic [NB_ADDR-1:0]  word_idx;
   logic [NB_DATA-1:0]  cur_word;
   logic [NB_DATA-1:0]  word_d;
   logic [NB_DATA-1:0]  wr_lanes;
   logic [NB_LANES-1:0] lane_we;
   logic [NB_DATA-1:0]  lane_shifted;
   logic [NB_DATA-1:0]  read_data;
   logic                misaligned;
   logic                wr_en;
   logic                dump_busy;
   logic                unused_addr_hi;

   // Byte address -> word index; higher address bits are dropped so accesses wrap.
   assign word_idx       = bus.i_addr[NB_ADDR+1:2];
   assign unused_addr_hi = ^bus.i_addr[NB_DATA-1:NB_ADDR+2];
   assign cur_word       = mem_q[word_idx];

   // Alignment is only reported for an actual load or store.
   always_comb begin
      misaligned = (bus.i_read | bus.i_write) &
                   size_misaligned(bus.i_word_size, bus.i_addr[1:0]);
   end

   // Lane enables and lane-replicated store data for the requested size.
   always_comb begin
      lane_we  = '0;
      wr_lanes = '0;
      case (bus.i_word_size)
         BYTE_WORD: begin
            lane_we[bus.i_addr[1:0]] = 1'b1;
            wr_lanes = {NB_LANES{bus.i_write_data[7:0]}};
         end
         HALF_WORD: begin
            lane_we[{bus.i_addr[1], 1'b0}] = 1'b1;
            lane_we[{bus.i_addr[1], 1'b1}] = 1'b1;
            wr_lanes = {(NB_LANES/2){bus.i_write_data[15:0]}};
         end
         COMPLETE_WORD: begin
            lane_we  = '1;
            wr_lanes = bus.i_write_data;
         end
         default: begin
            lane_we  = '0;
            wr_lanes = '0;
         end
      endcase
   end

   // Merge enabled lanes into the current word; untouched lanes keep their contents.
   always_comb begin
      word_d = cur_word;
      for (int l = 0; l < NB_LANES; l++) begin
         if (lane_we[l]) begin
            word_d[8*l +: 8] = wr_lanes[8*l +: 8];
         end
      end
   end

   assign wr_en = bus.i_write & ~misaligned & ~dump_busy;

   // Storage array: cleared by reset, one merged word written per accepted store.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (wr_en) begin
         mem_q[word_idx] <= word_d;
      end
   end

   // Right-justify the addressed lane(s) of the pre-edge word; zero on no-read or misalignment.
   assign lane_shifted = cur_word >> {bus.i_addr[1:0], 3'b000};
   always_comb begin
      read_data = '0;
      if (bus.i_read && !misaligned) begin
         case (bus.i_word_size)
            BYTE_WORD:     read_data[7:0]  = lane_shifted[7:0];
            HALF_WORD:     read_data[15:0] = lane_shifted[15:0];
            COMPLETE_WORD: read_data       = cur_word;
            default:       read_data       = '0;
         endcase
      end
   end

   assign bus.o_read_data  = read_data;
   assign bus.o_misaligned = misaligned;

`ifdef DMEM_DEBUG_DUMP_EN
   logic               dump_valid;
   logic               dump_done;
   logic [NB_ADDR-1:0] dump_ptr;

   dmem_dump_fsm #(
      .NB_ADDR (NB_ADDR)
   ) u_dump_fsm (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_dump_start (bus.i_dump_start),
      .i_dump_ready (bus.i_dump_ready),
      .o_dump_valid (dump_valid),
      .o_dump_busy  (dump_busy),
      .o_dump_done  (dump_done),
      .o_dump_addr  (dump_ptr)
   );

   assign bus.o_dump_valid = dump_valid;
   assign bus.o_dump_busy  = dump_busy;
   assign bus.o_dump_done  = dump_done;
   assign bus.o_dump_addr  = dump_ptr;
   assign bus.o_dump_data  = mem_q[dump_ptr];
`else
   logic unused_dump_in;

   assign unused_dump_in   = bus.i_dump_start | bus.i_dump_ready;
   assign dump_busy        = 1'b0;
   assign bus.o_dump_valid = 1'b0;
   assign bus.o_dump_busy  = 1'b0;
   assign bus.o_dump_done  = 1'b0;
   assign bus.o_dump_addr  = '0;
   assign bus.o_dump_data  = '0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: table of load/store vectors plus hand-written dump sequences.
// Latency: checks loads 1 ns after inputs settle; stores are checked on the following cycle.
// Backpressure: exercises i_dump_ready low mid-dump when DMEM_DEBUG_DUMP_EN is defined.
module tb_data_mem_unit;
   import data_mem_unit_pkg::*;

   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   data_mem_unit_if #(.NB_DATA(32), .NB_ADDR(5), .NB_TYPE(3)) bus ();

   data_mem_unit #(.NB_DATA(32), .NB_ADDR(5), .NB_TYPE(3)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_mis;
   } vec_t;

   localparam int NV = 24;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.i_write      = wr;
      bus.i_read       = rd;
      bus.i_word_size  = sz;
      bus.i_addr       = addr;
      bus.i_write_data = wdata;
   endtask

   // Word load at the next negedge, compared 1 ns later.
   task automatic load_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
      @(negedge clk);
      drive(1'b0, 1'b1, COMPLETE_WORD, addr, 32'h0);
      #1;
      chk(name, bus.o_read_data, exp);
   endtask

   task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      drive(1'b1, 1'b0, COMPLETE_WORD, addr, data);
   endtask

   task automatic idle_bus();
      drive(1'b0, 1'b0, BYTE_WORD, 32'h0, 32'h0);
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst_n = 1'b0;
      bus.i_dump_start = 1'b0;
      bus.i_dump_ready = 1'b0;
      idle_bus();

      //             wr    rd    size           addr        wdata         exp_rd        mis
      vt[0]  = '{1'b1, 1'b0, BYTE_WORD,     32'h06, 32'h000000A5, 32'h00000000, 1'b0};
      vt[1]  = '{1'b0, 1'b1, COMPLETE_WORD, 32'h04, 32'h0,        32'h00A50000, 1'b0};
      vt[2]  = '{1'b0, 1'b1, BYTE_WORD,     32'h06, 32'h0,        32'h000000A5, 1'b0};
      vt[3]  = '{1'b0, 1'b1, BYTE_WORD,     32'h05, 32'h0,        32'h00000000, 1'b0};
      vt[4]  = '{1'b0, 1'b1, HALF_WORD,     32'h06, 32'h0,        32'h000000A5, 1'b0};
      vt[5]  = '{1'b1, 1'b0, COMPLETE_WORD, 32'h08, 32'h11223344, 32'h00000000, 1'b0};
      vt[6]  = '{1'b1, 1'b0, HALF_WORD,     32'h0A, 32'h1234BEEF, 32'h00000000, 1'b0};
      vt[7]  = '{1'b0, 1'b1, COMPLETE_WORD, 32'h08, 32'h0,        32'hBEEF3344, 1'b0};
      vt[8]  = '{1'b0, 1'b1, HALF_WORD,     32'h08, 32'h0,        32'h00003344, 1'b0};
      vt[9]  = '{1'b0, 1'b1, BYTE_WORD,     32'h0B, 32'h0,        32'h000000BE, 1'b0};
      vt[10] = '{1'b1, 1'b0, COMPLETE_WORD, 32'h03, 32'hDEADBEEF, 32'h00000000, 1'b1};
      vt[11] = '{1'b0, 1'b1, COMPLETE_WORD, 32'h00, 32'h0,        32'h00000000, 1'b0};
      vt[12] = '{1'b0, 1'b1, COMPLETE_WORD, 32'h03, 32'h0,        32'h00000000, 1'b1};
      vt[13] = '{1'b0, 1'b1, HALF_WORD,     32'h09, 32'h0,        32'h00000000, 1'b1};
      vt[14] = '{1'b0, 1'b1, 3'b111,        32'h08, 32'h0,        32'h00000000, 1'b1};
      vt[15] = '{1'b0, 1'b0, COMPLETE_WORD, 32'h03, 32'h0,        32'h00000000, 1'b0};
      vt[16] = '{1'b1, 1'b0, COMPLETE_WORD, 32'h88, 32'hCAFEF00D, 32'h00000000, 1'b0};
      vt[17] = '{1'b1, 1'b1, COMPLETE_WORD, 32'h08, 32'h55667788, 32'hCAFEF00D, 1'b0};
      vt[18] = '{1'b0, 1'b1, COMPLETE_WORD, 32'h08, 32'h0,        32'h55667788, 1'b0};
      vt[19] = '{1'b1, 1'b0, BYTE_WORD,     32'h0F, 32'h0000007E, 32'h00000000, 1'b0};
      vt[20] = '{1'b0, 1'b1, COMPLETE_WORD, 32'h0C, 32'h0,        32'h7E000000, 1'b0};
      vt[21] = '{1'b1, 1'b0, HALF_WORD,     32'h0B, 32'h0000FFFF, 32'h00000000, 1'b1};
      vt[22] = '{1'b0, 1'b1, COMPLETE_WORD, 32'h08, 32'h0,        32'h55667788, 1'b0};
      vt[23] = '{1'b0, 1'b1, BYTE_WORD,     32'h07, 32'h0,        32'h00000000, 1'b0};

      // Reset state.
      #1;
      chk("reset dump_valid", {31'h0, bus.o_dump_valid}, 32'h0);
      chk("reset dump_busy",  {31'h0, bus.o_dump_busy},  32'h0);
      chk("reset dump_done",  {31'h0, bus.o_dump_done},  32'h0);
      chk("reset dump_addr",  {27'h0, bus.o_dump_addr},  32'h0);
      chk("reset dump_data",  bus.o_dump_data,           32'h0);
      chk("reset read_data",  bus.o_read_data,           32'h0);
      chk("reset misaligned", {31'h0, bus.o_misaligned}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load/store vector table.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vt[i].wr, vt[i].rd, vt[i].sz, vt[i].addr, vt[i].wdata);
         #1;
         chk($sformatf("vec%0d read_data", i), bus.o_read_data, vt[i].exp_rd);
         chk($sformatf("vec%0d misaligned", i), {31'h0, bus.o_misaligned}, {31'h0, vt[i].exp_mis});
      end
      @(negedge clk);
      idle_bus();

`ifdef DMEM_DEBUG_DUMP_EN
      begin
         int  n;
         int  dones;
         bit  held;
         bit  timeout;

         // Preload word i = i+1.
         for (int w = 0; w < 32; w++) begin
            store_word(w * 4, w + 1);
         end
         @(negedge clk);
         idle_bus();

         // Full dump with ready tied high and a store attempted mid-dump.
         bus.i_dump_ready = 1'b1;
         bus.i_dump_start = 1'b1;
         @(negedge clk);
         bus.i_dump_start = 1'b0;
         n = 0;
         dones = 0;
         for (int c = 0; c < 40; c++) begin
            if (bus.o_dump_valid) begin
               chk($sformatf("dump addr %0d", n), {27'h0, bus.o_dump_addr}, n);
               chk($sformatf("dump data %0d", n), bus.o_dump_data, n + 1);
               n++;
            end
            if (bus.o_dump_done) dones++;
            if (c == 5) drive(1'b1, 1'b0, COMPLETE_WORD, 32'h04, 32'hFFFFFFFF);
            else        idle_bus();
            @(negedge clk);
         end
         chk("dump word count", n, 32);
         chk("dump done pulses", dones, 1);
         chk("dump busy after", {31'h0, bus.o_dump_busy}, 32'h0);
         load_word("store during dump dropped", 32'h04, 32'h00000002);
         @(negedge clk);
         idle_bus();

         // Backpressure at word 7, then reset mid-dump.
         bus.i_dump_start = 1'b1;
         @(negedge clk);
         bus.i_dump_start = 1'b0;
         held = 1'b0;
         timeout = 1'b1;
         for (int c = 0; c < 20 && !held; c++) begin
            if (bus.o_dump_valid && bus.o_dump_addr == 5'd7) begin
               held = 1'b1;
               timeout = 1'b0;
               bus.i_dump_ready = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  @(negedge clk);
                  chk($sformatf("hold%0d valid", k), {31'h0, bus.o_dump_valid}, 32'h1);
                  chk($sformatf("hold%0d addr", k), {27'h0, bus.o_dump_addr}, 32'd7);
                  chk($sformatf("hold%0d data", k), bus.o_dump_data, 32'd8);
               end
               bus.i_dump_ready = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
         if (timeout) chk("reach word 7 timeout", 32'h1, 32'h0);
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
         chk("mid-dump addr advanced", {27'h0, bus.o_dump_addr}, 32'd10);
         chk("mid-dump busy", {31'h0, bus.o_dump_busy}, 32'h1);
         rst_n = 1'b0;
         #1;
         chk("rst dump_valid", {31'h0, bus.o_dump_valid}, 32'h0);
         chk("rst dump_busy",  {31'h0, bus.o_dump_busy},  32'h0);
         chk("rst dump_done",  {31'h0, bus.o_dump_done},  32'h0);
         chk("rst dump_addr",  {27'h0, bus.o_dump_addr},  32'h0);
         chk("rst dump_data",  bus.o_dump_data,           32'h0);
         @(negedge clk);
         rst_n = 1'b1;
         load_word("mem cleared w1", 32'h04, 32'h0);
         load_word("mem cleared w7", 32'h1C, 32'h0);
         @(negedge clk);
         idle_bus();
         chk("idle after reset", {31'h0, bus.o_dump_busy}, 32'h0);
      end
`else
      // Without the dump engine, start is ignored and stores go through.
      bus.i_dump_ready = 1'b1;
      @(negedge clk);
      bus.i_dump_start = 1'b1;
      drive(1'b1, 1'b0, COMPLETE_WORD, 32'h10, 32'h0BADF00D);
      @(negedge clk);
      bus.i_dump_start = 1'b0;
      idle_bus();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("nodump%0d busy", k),  {31'h0, bus.o_dump_busy},  32'h0);
         chk($sformatf("nodump%0d valid", k), {31'h0, bus.o_dump_valid}, 32'h0);
         @(negedge clk);
      end
      load_word("store with start pulsed", 32'h10, 32'h0BADF00D);
      @(negedge clk);
      idle_bus();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
